// File: rtl/fill_sched_pkg.sv
// Shared definitions for the fill phase scheduler: state/Phase encodings
// and the default phase-length and sizing constants.
package fill_sched_pkg;

  // State register width; the state code doubles as the Phase output value.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_PH1  = 3'd1;
  localparam state_t ST_PH2  = 3'd2;
  localparam state_t ST_PH3  = 3'd3;
  localparam state_t ST_PH4  = 3'd4;
  localparam state_t ST_PH5  = 3'd5;

  // Default phase lengths in cycles.
  localparam int P1_LEN_DEF = 2;
  localparam int P2_LEN_DEF = 3;
  localparam int P3_LEN_DEF = 4;
  localparam int P4_LEN_DEF = 2;
  localparam int P5_LEN_DEF = 1;

  // Default phase counter width and request queue depth.
  localparam int CNT_W_DEF  = 16;
  localparam int DEPTH_DEF  = 4;

endpackage

// File: rtl/fill_phase_scheduler_counter.sv
// Shared loadable down-counter used to time every phase. Load wins over
// decrement; the counter saturates at zero.
module phase_counter
  import fill_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load a new phase length, otherwise count down towards zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/fill_phase_scheduler.sv
// Five-phase fill scheduler: queues frame-start requests and walks each
// frame through PH1..PH5 using one shared phase counter. Frames run
// back-to-back from PH5 into PH1 while requests are pending.
module fill_phase_scheduler
  import fill_sched_pkg::*;
#(
  parameter int P1_LEN = P1_LEN_DEF,
  parameter int P2_LEN = P2_LEN_DEF,
  parameter int P3_LEN = P3_LEN_DEF,
  parameter int P4_LEN = P4_LEN_DEF,
  parameter int P5_LEN = P5_LEN_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic       S_AXIS_ACLK,
  input  logic       S_AXIS_ARESETN,
  input  logic       Din_Valid,
  output logic       Din_Ready,
  output logic [2:0] Phase,
  output logic       Sel_Valid,
  output logic       Dout_Valid,
  output logic       Busy,
  output logic [3:0] Pending,
  output logic       Drop
);

  // Counter load values: a phase of length N holds for N cycles, so load N-1.
  localparam logic [CNT_W-1:0] P1_LD = CNT_W'(P1_LEN - 1);
  localparam logic [CNT_W-1:0] P2_LD = CNT_W'(P2_LEN - 1);
  localparam logic [CNT_W-1:0] P3_LD = CNT_W'(P3_LEN - 1);
  localparam logic [CNT_W-1:0] P4_LD = CNT_W'(P4_LEN - 1);
  localparam logic [CNT_W-1:0] P5_LD = CNT_W'(P5_LEN - 1);
  localparam logic [3:0]       DEPTH_C = 4'(DEPTH);

  state_t           state_q, state_d;
  logic [3:0]       pend_q, pend_d;
  logic             drop_q, drop_d;
  logic             sel_q, sel_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;

  logic             accept_s;
  logic             start_s;
  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic             cnt_zero_s;
  logic [CNT_W-1:0] cnt_load_val_s;

  assign Din_Ready = (pend_q < DEPTH_C);
  assign accept_s  = Din_Valid && Din_Ready;

  phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk      (S_AXIS_ACLK),
    .rst_n    (S_AXIS_ARESETN),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // Phase sequencing: advance on counter zero, start frames from the queue.
  always_comb begin
    state_d        = state_q;
    start_s        = 1'b0;
    cnt_load_s     = 1'b0;
    cnt_dec_s      = 1'b0;
    cnt_load_val_s = {CNT_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (pend_q != 4'd0) begin
          state_d        = ST_PH1;
          start_s        = 1'b1;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = P1_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PH1: begin
        if (cnt_zero_s) begin
          state_d        = ST_PH2;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = P2_LD;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_PH2: begin
        if (cnt_zero_s) begin
          state_d        = ST_PH3;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = P3_LD;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_PH3: begin
        if (cnt_zero_s) begin
          state_d        = ST_PH4;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = P4_LD;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_PH4: begin
        if (cnt_zero_s) begin
          state_d        = ST_PH5;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = P5_LD;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_PH5: begin
        if (cnt_zero_s && (pend_q != 4'd0)) begin
          state_d        = ST_PH1;
          start_s        = 1'b1;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = P1_LD;
        end else if (cnt_zero_s) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending queue count; accept and start on the same edge cancel out.
  // Accept needs pend_q < DEPTH and start needs pend_q > 0, so it cannot wrap.
  always_comb begin
    pend_d = pend_q;
    if (accept_s && !start_s) begin
      pend_d = pend_q + 4'd1;
    end else if (start_s && !accept_s) begin
      pend_d = pend_q - 4'd1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Output decodes computed from next state so the outputs come straight off flops.
  always_comb begin
    drop_d = drop_q | (Din_Valid & ~Din_Ready);
    sel_d  = (state_d == ST_PH2) || (state_d == ST_PH3);
    dout_d = (state_d == ST_PH4);
    busy_d = (state_d != ST_IDLE) || (pend_d != 4'd0);
  end

  // State, queue and output registers, cleared asynchronously.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q <= ST_IDLE;
      pend_q  <= 4'd0;
      drop_q  <= 1'b0;
      sel_q   <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  assign Phase      = state_q;
  assign Pending    = pend_q;
  assign Drop       = drop_q;
  assign Sel_Valid  = sel_q;
  assign Dout_Valid = dout_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_fill_phase_scheduler.sv
// Directed bench for fill_phase_scheduler. A timeline model keeps a queue of
// expected Phase values per cycle; frames are pushed when the model starts
// them and popped/compared after every clock edge.
module tb_fill_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [2:0] phase;
  logic       sel_valid, dout_valid, busy, drop;
  logic [3:0] pending;

  // Second instance with all phase lengths 1.
  logic       v1 = 1'b0;
  logic       r1;
  logic [2:0] ph1;
  logic       s1, d1, b1, dr1;
  logic [3:0] pd1;

  int checks = 0;
  int fails  = 0;

  // Model state.
  int m_q[$];
  int m_pend = 0;
  int m_drop = 0;
  int m_ph   = 0;
  int frames_done = 0;
  int sel_cnt = 0;
  int dout_cnt = 0;

  always #5 clk = ~clk;

  fill_phase_scheduler u_dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .Din_Valid      (din_valid),
    .Din_Ready      (din_ready),
    .Phase          (phase),
    .Sel_Valid      (sel_valid),
    .Dout_Valid     (dout_valid),
    .Busy           (busy),
    .Pending        (pending),
    .Drop           (drop)
  );

  fill_phase_scheduler #(
    .P1_LEN (1), .P2_LEN (1), .P3_LEN (1), .P4_LEN (1), .P5_LEN (1)
  ) u_dut1 (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .Din_Valid      (v1),
    .Din_Ready      (r1),
    .Phase          (ph1),
    .Sel_Valid      (s1),
    .Dout_Valid     (d1),
    .Busy           (b1),
    .Pending        (pd1),
    .Drop           (dr1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected phase timeline of one frame with the default lengths 2,3,4,2,1.
  task automatic push_frame();
    int lens[5] = '{2, 3, 4, 2, 1};
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < lens[p]; c++) m_q.push_back(p + 1);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_phase"},   phase,      m_ph);
    check({tag, "_pending"}, pending,    m_pend);
    check({tag, "_drop"},    drop,       m_drop);
    check({tag, "_sel"},     sel_valid,  (m_ph == 2 || m_ph == 3) ? 1 : 0);
    check({tag, "_dout"},    dout_valid, (m_ph == 4) ? 1 : 0);
    check({tag, "_busy"},    busy,       (m_ph != 0 || m_pend != 0) ? 1 : 0);
  endtask

  // One clock cycle: drive request, advance model on the edge, compare.
  task automatic tick(input logic v);
    int m_ready;
    int prev_ph;
    @(negedge clk);
    din_valid = v;
    m_ready = (m_pend < 4) ? 1 : 0;
    check("din_ready", din_ready, m_ready);
    if (v && m_ready == 0) m_drop = 1;
    if (m_q.size() == 0 && m_pend > 0) begin
      push_frame();
      m_pend--;
    end
    if (v && m_ready == 1) m_pend++;
    prev_ph = phase;
    @(posedge clk);
    #1;
    m_ph = (m_q.size() != 0) ? m_q.pop_front() : 0;
    if (prev_ph == 5 && phase != 3'd5) frames_done++;
    if (sel_valid) sel_cnt++;
    if (dout_valid) dout_cnt++;
    check_all("cyc");
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((m_q.size() != 0 || m_pend != 0 || m_ph != 0) && n < 200) begin
      tick(1'b0);
      n++;
    end
    check({tag, "_drain_timeout"}, (n < 200) ? 1 : 0, 1);
  endtask

  initial begin
    int n;
    int exp1[11] = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 0};

    // Reset state.
    #2;
    check_all("reset");
    check("reset_ready", din_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single frame with default lengths.
    sel_cnt = 0; dout_cnt = 0;
    tick(1'b1);
    for (int i = 0; i < 15; i++) tick(1'b0);
    check("single_sel_cycles", sel_cnt, 7);
    check("single_dout_cycles", dout_cnt, 2);

    // Two requests on consecutive edges: back-to-back frames.
    tick(1'b1);
    tick(1'b1);
    check("b2b_pend_after_second", pending, 1);
    drain("b2b");

    // Six requests while busy: queue fills, one is dropped, five frames run.
    frames_done = 0;
    for (int i = 0; i < 6; i++) tick(1'b1);
    check("ovf_pending_full", pending, 4);
    check("ovf_drop", drop, 1);
    check("ovf_ready_low", din_ready, 0);
    drain("ovf");
    check("ovf_frames", frames_done, 5);

    // Request arriving on the final PH5 cycle with one request queued.
    tick(1'b1);
    tick(1'b1);
    n = 0;
    while (!(m_q.size() == 0 && m_ph == 5) && n < 50) begin
      tick(1'b0);
      n++;
    end
    check("coinc_reach_ph5", (n < 50) ? 1 : 0, 1);
    tick(1'b1);
    check("coinc_pending", pending, 1);
    check("coinc_phase", phase, 1);
    drain("coinc");

    // Reset in PH3 with two requests queued.
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    n = 0;
    while (m_ph != 3 && n < 20) begin
      tick(1'b0);
      n++;
    end
    check("rst_pend_before", pending, 2);
    #2;
    din_valid = 1'b0;
    rst_n = 1'b0;
    m_q.delete();
    m_pend = 0; m_drop = 0; m_ph = 0;
    #1;
    check_all("midrst");
    check("midrst_ready", din_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick(1'b0);

    // All phase lengths 1: two back-to-back five-cycle frames.
    @(negedge clk);
    v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    // Edges 0 and 1 have passed; phase after edge 1 is already visible.
    check("len1_phase_e1", ph1, exp1[0]);
    for (int i = 1; i < 11; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("len1_phase_e%0d", i + 1), ph1, exp1[i]);
    end
    check("len1_drop", dr1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/fill_phase_scheduler.md
FILL_PHASE_SCHEDULER -- requirements
Module: fill_phase_scheduler

Interface
REQ-001 Parameters SHALL be: P1_LEN 2, P2_LEN 3, P3_LEN 4, P4_LEN 2, P5_LEN 1 (phase lengths in cycles, each 1..2^CNT_W-1); CNT_W 16 (phase counter width); DEPTH 4 (max pending frame requests, 1..15).
REQ-002 Ports SHALL be:
- S_AXIS_ACLK  in  1  sole clock, rising edge.
- S_AXIS_ARESETN  in  1  asynchronous active-low reset.
- Din_Valid  in  1  one-cycle frame-start request.
- Din_Ready  out  1  request will be accepted this cycle.
- Phase  out  3  current phase: 0 idle, 1..5 = PH1..PH5.
- Sel_Valid  out  1  selector enable for the fill datapath.
- Dout_Valid  out  1  output-data qualifier.
- Busy  out  1  state not IDLE or pending count nonzero.
- Pending  out  4  queued, not-yet-started requests.
- Drop  out  1  sticky: a request arrived while Din_Ready was low.

Function
REQ-003 The block SHALL replace the five separate phase timers with one shared loadable down-counter of CNT_W bits.
REQ-004 States SHALL be IDLE, PH1, PH2, PH3, PH4, PH5; Phase encodes them 0..5.
REQ-005 Din_Ready SHALL be combinational: high when Pending < DEPTH.
REQ-006 A request SHALL be accepted on a rising edge where Din_Valid and Din_Ready are both high; acceptance increments Pending.
REQ-007 IDLE SHALL move to PH1 on the edge where Pending > 0, decrement Pending, and load counter with P1_LEN-1.
REQ-008 In PHn the counter SHALL decrement each cycle; when it is 0, the next edge SHALL enter PH(n+1) and load P(n+1)_LEN-1; PHn therefore lasts exactly Pn_LEN cycles.
REQ-009 On counter 0 in PH5: if Pending > 0, the next edge SHALL enter PH1 directly (back-to-back, no IDLE cycle), decrement Pending and load P1_LEN-1; otherwise it SHALL enter IDLE.
REQ-010 Same-edge acceptance and frame start SHALL leave Pending unchanged (net 0); Din_Ready is evaluated on the pre-edge Pending value.
REQ-011 Latency: request accepted at edge k from IDLE with Pending 0 SHALL give Phase=1 after edge k+1.
REQ-012 Sel_Valid SHALL be high exactly in PH2 and PH3; Dout_Valid SHALL be high exactly in PH4; both registered-state decodes, glitch-free.
REQ-013 Drop SHALL set on any edge where Din_Valid is high and Din_Ready is low, hold until reset; the dropped request SHALL have no other effect.
REQ-014 Pending SHALL never exceed DEPTH nor underflow below 0.
REQ-015 Phase lengths of 1 SHALL be honoured (single-cycle phase, no skipped or doubled phase).

Reset
REQ-016 Asserting S_AXIS_ARESETN low SHALL immediately force: state IDLE, Phase 0, counter 0, Pending 0, Drop 0, Sel_Valid 0, Dout_Valid 0, Busy 0; Din_Ready then reads 1.
REQ-017 Reset mid-frame SHALL abandon the frame and all pending requests; no outputs asserted on the first edge after deassertion.

Structure
REQ-018 A shared package fill_sched_pkg SHALL hold the state enumeration, Phase encodings and default phase-length constants.
REQ-019 One sub-module, phase_counter (load value, load strobe, decrement, zero flag, CNT_W wide), SHALL be instantiated; the FSM and Pending counter stay in the top.

Verification
REQ-020 Single request, defaults: Din_Valid pulse at edge 0 -> Phase 1 for cycles 2-3, 2 for 4-6, 3 for 7-10, 4 for 11-12, 5 for 13, IDLE at 14; Sel_Valid high 7 cycles, Dout_Valid high 2 cycles.
REQ-021 Two requests at edges 0 and 1 -> second frame PH1 starts cycle 14 with no IDLE gap; Pending goes 1,1,0 (frame 1 start, frame 2 queued, frame 2 start).
REQ-022 Six consecutive Din_Valid pulses while busy with DEPTH 4 -> Pending reaches 4, Din_Ready low, Drop sets on the overflow request, exactly 5 frames complete.
REQ-023 Request coincident with PH5 counter 0 and Pending 1 -> Pending stays 1, PH1 entered next edge.
REQ-024 Reset asserted during PH3 with Pending 2 -> all outputs reset immediately; after deassertion, no activity until a new Din_Valid.
REQ-025 All P*_LEN = 1 -> each frame lasts exactly 5 cycles, Phase steps 1..5 with no repetition.
